// File: rtl/sme_pkg.sv
// +----------------------------------------------------------------------------+
// | sme_pkg : shared constants, FSM state type and result record for sme_param |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sme_pkg;

    localparam logic [7:0] CH_WILD  = 8'h2E;
    localparam logic [7:0] CH_HEAD  = 8'h5E;
    localparam logic [7:0] CH_TAIL  = 8'h24;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // Result index is held wide; the top truncates to its own IDX_W.
    localparam int RES_IDX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_STR = 2'd1,
        ST_LOAD_PAT = 2'd2,
        ST_SEARCH   = 2'd3
    } state_t;

    typedef struct packed {
        logic                 match;
        logic [RES_IDX_W-1:0] index;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/sme_window_cmp.sv
// +----------------------------------------------------------------------------+
// | sme_window_cmp : combinational test of the pattern core at one position    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sme_window_cmp #(
    parameter int DATA_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX),
    parameter int PL_W    = $clog2(PAT_MAX + 1)
) (
    input  logic [STR_MAX-1:0][DATA_W-1:0] i_str,
    input  logic [IDX_W:0]                 i_len,
    input  logic [IDX_W:0]                 i_pos,
    input  logic [PAT_MAX-1:0][DATA_W-1:0] i_core,
    input  logic [PL_W-1:0]                i_k,
    input  logic                           i_head,
    input  logic                           i_tail,
    output logic                           o_hit
);
    import sme_pkg::*;

    localparam int SUM_W = IDX_W + 2;

    logic [PAT_MAX-1:0][DATA_W-1:0] w_win;
    logic [DATA_W-1:0]              w_prev;
    logic [DATA_W-1:0]              w_next;
    logic [SUM_W-1:0]               w_end;
    logic                           w_fit;
    logic                           w_core_ok;

    assign w_end = SUM_W'(i_pos) + SUM_W'(i_k);
    assign w_fit = (i_k != '0) && (w_end <= SUM_W'(i_len));

    // Window and neighbour characters are muxed by position; slots past the
    // buffer read as zero and are masked out by w_fit anyway.
    always_comb begin
        w_win  = '0;
        w_prev = '0;
        w_next = '0;
        for (int i = 0; i < STR_MAX; i++) begin
            for (int k = 0; k < PAT_MAX; k++) begin
                if (SUM_W'(i) == SUM_W'(i_pos) + SUM_W'(k))
                    w_win[k] = i_str[i];
            end
            if (SUM_W'(i + 1) == SUM_W'(i_pos))
                w_prev = i_str[i];
            if (SUM_W'(i) == w_end)
                w_next = i_str[i];
        end
    end

    always_comb begin
        w_core_ok = 1'b1;
        for (int k = 0; k < PAT_MAX; k++) begin
            if ((PL_W'(k) < i_k) && (i_core[k] != DATA_W'(CH_WILD)) && (w_win[k] != i_core[k]))
                w_core_ok = 1'b0;
        end
    end

    assign o_hit = w_fit && w_core_ok
                && (!i_head || (i_pos == '0) || (w_prev == DATA_W'(CH_SPACE)))
                && (!i_tail || (w_end == SUM_W'(i_len)) || (w_next == DATA_W'(CH_SPACE)));

endmodule

`default_nettype wire

// File: rtl/sme_param.sv
// +----------------------------------------------------------------------------+
// | sme_param : parametrised string matcher with '.', '^' and '$' support      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sme_param #(
    parameter int DATA_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              busy
);
    import sme_pkg::*;

    localparam int             PL_W      = $clog2(PAT_MAX + 1);
    localparam int             PI_W      = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam logic [IDX_W:0] C_STR_MAX = (IDX_W + 1)'(STR_MAX);
    localparam logic [IDX_W:0] C_N_ONE   = (IDX_W + 1)'(1);
    localparam logic [PL_W-1:0] C_PAT_MAX = PL_W'(PAT_MAX);
    localparam logic [PL_W-1:0] C_L_ONE   = PL_W'(1);

    state_t                         r_state;
    logic [STR_MAX-1:0][DATA_W-1:0] r_str;
    logic [PAT_MAX-1:0][DATA_W-1:0] r_pat;
    logic [PAT_MAX-1:0][DATA_W-1:0] r_core;
    logic [IDX_W:0]                 r_n;
    logic [IDX_W:0]                 r_s;
    logic [PL_W-1:0]                r_l;
    logic [PL_W-1:0]                r_k;
    logic                           r_head;
    logic                           r_tail;
    logic                           r_valid;
    logic                           r_busy;
    result_t                        r_res;

    logic                           w_head;
    logic                           w_tail;
    logic                           w_hit;
    logic [DATA_W-1:0]              w_last;
    logic [PL_W-1:0]                w_k;
    logic [PAT_MAX-1:0][DATA_W-1:0] w_core;

    // Anchor decode; a lone '^' is never also treated as a tail anchor.
    always_comb begin
        w_head = (r_l != '0) && (r_pat[0] == DATA_W'(CH_HEAD));
        w_last = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (PL_W'(i + 1) == r_l)
                w_last = r_pat[i];
        end
        w_tail = (r_l != '0) && (w_last == DATA_W'(CH_TAIL)) && (r_l > PL_W'(w_head));
        w_k    = r_l - PL_W'(w_head) - PL_W'(w_tail);
        w_core = w_head ? (r_pat >> DATA_W) : r_pat;
    end

    sme_window_cmp #(
        .DATA_W  (DATA_W),
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX),
        .IDX_W   (IDX_W),
        .PL_W    (PL_W)
    ) u_cmp (
        .i_str  (r_str),
        .i_len  (r_n),
        .i_pos  (r_s),
        .i_core (r_core),
        .i_k    (r_k),
        .i_head (r_head),
        .i_tail (r_tail),
        .o_hit  (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_l     <= '0;
            r_s     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_res   <= '0;
            if (isstring) begin
                r_busy <= 1'b0;
                if (r_state != ST_LOAD_STR) begin
                    r_str[0] <= chardata;
                    r_n      <= C_N_ONE;
                    r_state  <= ST_LOAD_STR;
                end else if (r_n < C_STR_MAX) begin
                    r_str[r_n[IDX_W-1:0]] <= chardata;
                    r_n                   <= r_n + C_N_ONE;
                end
            end else if (ispattern) begin
                r_busy <= 1'b0;
                if (r_state != ST_LOAD_PAT) begin
                    r_pat[0] <= chardata;
                    r_l      <= C_L_ONE;
                    r_state  <= ST_LOAD_PAT;
                end else if (r_l < C_PAT_MAX) begin
                    r_pat[r_l[PI_W-1:0]] <= chardata;
                    r_l                  <= r_l + C_L_ONE;
                end
            end else begin
                case (r_state)
                    ST_LOAD_STR, ST_LOAD_PAT: begin
                        if ((r_l != '0) && (r_n != '0)) begin
                            r_state <= ST_SEARCH;
                            r_s     <= '0;
                            r_busy  <= 1'b1;
                            r_core  <= w_core;
                            r_k     <= w_k;
                            r_head  <= w_head;
                            r_tail  <= w_tail;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_SEARCH: begin
                        if (w_hit) begin
                            r_valid     <= 1'b1;
                            r_res.match <= 1'b1;
                            r_res.index <= RES_IDX_W'(r_s);
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else if (r_s == r_n - C_N_ONE) begin
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_s <= r_s + C_N_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign valid       = r_valid;
    assign match       = r_res.match;
    assign match_index = IDX_W'(r_res.index);
    assign busy        = r_busy;

endmodule

`default_nettype wire
